npc_bpred: RTL and testbench
============================

// Module: npc_bpred
// PURPOSE
//  Parametrised next-PC unit for the MIPS pipeline with a direct-mapped branch target buffer (BTB)
//  and 2-bit saturating counters. Generates the IF next-PC each cycle and honours the one-instruction
//  delay slot. Branch/jump resolution moves to EX; a mispredict redirects fetch and kills one IF slot.
//  Comparator ops: 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez.
// PARAMETERS
//  ENTRIES   16   BTB entries, power of 2, >= 2
//  IDX_W     4    log2(ENTRIES); index = pc[IDX_W+1:2]
//  TAG_W     8    tag = pc[IDX_W+TAG_W+1:IDX_W+2]
//  CNT_W     32   width of the performance counters
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous reset, active-low
//  fetch_en       in   1      IF advances this cycle (0 = stall)
//  pc_f           in   32     PC of the instruction in IF
//  npc_f          out  32     next PC to load into the PC register
//  pred_taken_f   out  1      prediction for pc_f; carried down the pipe to EX
//  pred_tgt_f     out  32     predicted target for pc_f; carried down the pipe to EX
//  flush_f        out  1      kill the instruction now in IF (turn it into a nop)
//  ex_valid       in   1      EX holds a control-transfer instruction that resolves this cycle
//  ex_type        in   2      0 branch, 1 j/jal, 2 jr/jalr
//  ex_cmpop       in   3      comparator op; used only when ex_type==0
//  ex_pc          in   32     PC of the EX instruction
//  ex_a, ex_b     in   32     forwarded rs / rt values
//  ex_imm32       in   32     sign-extended offset (branch)
//  ex_imm26       in   26     jump index (j/jal)
//  ex_pred_taken  in   1      pred_taken_f carried down from IF
//  ex_pred_tgt    in   32     pred_tgt_f carried down from IF
//  perf_br        out  CNT_W  resolved control transfers
//  perf_miss      out  CNT_W  mispredicts
// BEHAVIOUR
//  - Reset: all BTB valid bits = 0, all counters = 2'b01, pend_vld = 0, perf counters = 0.
//    Outputs from reset: flush_f = 0, pred_taken_f = 0, npc_f = pc_f+4.
//  - Lookup (combinational, in IF): hit = valid[idx] && tag match. pred_taken_f = hit && cnt[1].
//    pred_tgt_f = the entry target on a hit, otherwise 0.
//  - Delay slot: a taken prediction never skips the delay slot. Predicted taken -> npc_f = pc_f+4
//    and, at the edge where fetch_en=1, pend_vld<=1 and pend_tgt<=pred_tgt_f.
//    Next fetch cycle with pend_vld=1 -> npc_f = pend_tgt; pend_vld is cleared at the next fetch_en edge.
//    Delay-slot fetch does not look up its own prediction: pred_taken_f = 0.
//  - Resolution (EX, combinational):
//    - actual target: branch taken -> ex_pc+4+(ex_imm32<<2); branch not taken -> ex_pc+8;
//      j/jal -> {ex_pc[31:28],ex_imm26,2'b00}; jr -> ex_a.
//    - predicted next = ex_pred_taken ? ex_pred_tgt : ex_pc+8.
//    - mispredict = ex_valid && (actual != predicted).
//  - Redirect: mispredict -> npc_f = actual and flush_f = 1 in the same cycle. The delay slot is in ID
//    and is kept; the IF instruction is killed (1-cycle penalty).
//    Redirect overrides pend_vld and the lookup, and clears pend_vld at the edge.
//    The top level loads the PC when fetch_en || flush_f.
//  - Update at the edge when ex_valid=1 (registers are written at the edge, so a same-cycle IF lookup
//    sees the old entry):
//    - branch, hit: counter +1 if taken / -1 if not, saturating 0..3; on taken also write the target.
//    - branch, miss, taken: allocate {valid,tag,target}, counter 2'b10. Miss not taken: no write.
//    - j/jal: allocate or overwrite, counter 2'b11.
//    - jr: never allocated. It mispredicts unless ex_a == ex_pc+8.
//    - Tag conflict: the newer entry replaces the older one.
//  - Perf: perf_br +1 per ex_valid; perf_miss +1 per mispredict. Both saturate at all-ones.
//  - Reset asserted mid-operation: the state is cleared at once; a pending target is dropped.
//  - ex_cmpop values 6/7: the branch is resolved as not taken.
// TESTING
//  1 Reset, then fetch from 0x3000 with no branches -> npc_f = pc_f+4 every cycle, flush_f = 0, perfs 0.
//  2 beq at 0x3000 (a==b, offset 3), cold BTB -> EX: flush_f=1, npc_f=0x3010.
//    Second run: IF 0x3000 pred_taken_f=1; 0x3004 fetched, then 0x3010; no flush; perf_miss=1.
//  3 bne trained to counter 3, then not taken -> flush_f=1, npc_f=ex_pc+8; counter 2, still predicts taken.
//  4 jr with ex_a=0x3400 -> flush_f=1, npc_f=0x3400; no BTB write; j allocated with counter 3.
//  5 Predicted-taken fetch with fetch_en=0 for 3 cycles -> pend_tgt held; applied after the delay slot.
//    Mispredict in the pend cycle -> the actual target wins and pend_vld is cleared.
//  6 Two PCs aliasing the same index (0x3000, 0x3040 at ENTRIES=16) -> the latest wins;
//    the lookup of the other misses on tag; reset pulse mid-run clears all state.

Source files
------------

// File: rtl/npc_bpred.sv
// Next-PC unit with direct-mapped BTB and 2-bit counters for a MIPS pipeline with one delay slot.
// Prediction happens in IF, branch/jump resolution happens in EX, and a mispredict redirects fetch and kills the IF slot.
module npc_bpred #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic [31:0]      pc_f,
  output logic [31:0]      npc_f,
  output logic             pred_taken_f,
  output logic [31:0]      pred_tgt_f,
  output logic             flush_f,
  input  logic             ex_valid,
  input  logic [1:0]       ex_type,
  input  logic [2:0]       ex_cmpop,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_a,
  input  logic [31:0]      ex_b,
  input  logic [31:0]      ex_imm32,
  input  logic [25:0]      ex_imm26,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_tgt,
  output logic [CNT_W-1:0] perf_br,
  output logic [CNT_W-1:0] perf_miss
);

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];

  logic             pend_vld_q, pend_vld_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] perf_br_q, perf_br_d;
  logic [CNT_W-1:0] perf_miss_q, perf_miss_d;

  logic [IDX_W-1:0] idx_f, idx_x;
  logic [TAG_W-1:0] tag_f, tag_x;
  logic             hit_f, hit_x;
  logic             br_taken;
  logic [31:0]      actual_x, predicted_x;
  logic             mispred;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_x = ex_pc[IDX_W+1:2];
  assign tag_x = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_x = valid_q[idx_x] && (tag_q[idx_x] == tag_x);

  always_comb begin
    br_taken = 1'b0;
    case (ex_cmpop)
      3'd0:    br_taken = (ex_a == ex_b);
      3'd1:    br_taken = (ex_a != ex_b);
      3'd2:    br_taken = ex_a[31] || (ex_a == '0);
      3'd3:    br_taken = !ex_a[31] && (ex_a != '0);
      3'd4:    br_taken = ex_a[31];
      3'd5:    br_taken = !ex_a[31];
      default: br_taken = 1'b0;
    endcase

    actual_x = ex_a;
    case (ex_type)
      2'd0:    actual_x = br_taken ? (ex_pc + 32'd4 + (ex_imm32 << 2)) : (ex_pc + 32'd8);
      2'd1:    actual_x = {ex_pc[31:28], ex_imm26, 2'b00};
      default: actual_x = ex_a;
    endcase

    predicted_x = ex_pred_taken ? ex_pred_tgt : (ex_pc + 32'd8);
    mispred     = ex_valid && (actual_x != predicted_x);
  end

  // The delay-slot fetch does not make its own prediction, so the pending redirect is never stacked.
  always_comb begin
    pred_taken_f = !pend_vld_q && hit_f && cnt_q[idx_f][1];
    pred_tgt_f   = hit_f ? tgt_q[idx_f] : '0;
    flush_f      = mispred;
    if (mispred)         npc_f = actual_x;
    else if (pend_vld_q) npc_f = pend_tgt_q;
    else                 npc_f = pc_f + 32'd4;
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (mispred) begin
      pend_vld_d = 1'b0;
    end else if (fetch_en) begin
      if (pend_vld_q) begin
        pend_vld_d = 1'b0;
      end else if (pred_taken_f) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = pred_tgt_f;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (ex_valid) begin
      case (ex_type)
        2'd0: begin
          if (hit_x) begin
            if (br_taken) begin
              tgt_d[idx_x] = actual_x;
              if (cnt_q[idx_x] != 2'b11) cnt_d[idx_x] = cnt_q[idx_x] + 2'd1;
            end else if (cnt_q[idx_x] != 2'b00) begin
              cnt_d[idx_x] = cnt_q[idx_x] - 2'd1;
            end
          end else if (br_taken) begin
            valid_d[idx_x] = 1'b1;
            tag_d[idx_x]   = tag_x;
            tgt_d[idx_x]   = actual_x;
            cnt_d[idx_x]   = 2'b10;
          end
        end
        2'd1: begin
          valid_d[idx_x] = 1'b1;
          tag_d[idx_x]   = tag_x;
          tgt_d[idx_x]   = actual_x;
          cnt_d[idx_x]   = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    perf_br_d   = perf_br_q;
    perf_miss_d = perf_miss_q;
    if (ex_valid && (perf_br_q != '1))  perf_br_d   = perf_br_q + CNT_W'(1);
    if (mispred && (perf_miss_q != '1)) perf_miss_d = perf_miss_q + CNT_W'(1);
  end

  assign perf_br   = perf_br_q;
  assign perf_miss = perf_miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= '0;
      perf_br_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      perf_br_q   <= perf_br_d;
      perf_miss_q <= perf_miss_d;
    end
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: a behavioural next-PC/BTB model is checked on every cycle,
// alongside literal expectations that are worked out by hand for each scenario.
module tb_npc_bpred;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc_f;
  logic [31:0] npc_f;
  logic        pred_taken_f;
  logic [31:0] pred_tgt_f;
  logic        flush_f;
  logic        ex_valid;
  logic [1:0]  ex_type;
  logic [2:0]  ex_cmpop;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm32;
  logic [25:0] ex_imm26;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_tgt;
  logic [31:0] perf_br, perf_miss;

  always #5 clk = ~clk;

  npc_bpred #(.ENTRIES(16), .IDX_W(4), .TAG_W(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_f(pc_f),
    .npc_f(npc_f), .pred_taken_f(pred_taken_f), .pred_tgt_f(pred_tgt_f), .flush_f(flush_f),
    .ex_valid(ex_valid), .ex_type(ex_type), .ex_cmpop(ex_cmpop), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm32(ex_imm32), .ex_imm26(ex_imm26),
    .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt),
    .perf_br(perf_br), .perf_miss(perf_miss)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each slot remembers which PC last claimed it; a lookup hits when that PC shares the tag.
  bit          m_vld   [16];
  logic [31:0] m_owner [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  bit          m_pend;
  logic [31:0] m_ptgt;
  longint      m_br, m_miss;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_vld[slot(pc)] && (((m_owner[slot(pc)] >> 6) & 32'hff) == ((pc >> 6) & 32'hff));
  endfunction

  bit          e_pt, e_tk, e_miss, e_hit;
  logic [31:0] e_ptgt, e_act, e_pred, e_npc;
  int          sa, sx;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 16; i++) begin
          m_vld[i] = 0; m_owner[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
        end
        m_pend = 0; m_ptgt = '0; m_br = 0; m_miss = 0;
      end
      e_pt   = !m_pend && m_hit(pc_f) && (m_cnt[slot(pc_f)] >= 2);
      e_ptgt = m_hit(pc_f) ? m_tgt[slot(pc_f)] : 32'h0;
      sa = $signed(ex_a);
      case (ex_cmpop)
        3'd0: e_tk = (ex_a == ex_b);
        3'd1: e_tk = (ex_a != ex_b);
        3'd2: e_tk = (sa <= 0);
        3'd3: e_tk = (sa > 0);
        3'd4: e_tk = (sa < 0);
        3'd5: e_tk = (sa >= 0);
        default: e_tk = 0;
      endcase
      if (ex_type == 2'd0)      e_act = e_tk ? ex_pc + 4 + ex_imm32 * 4 : ex_pc + 8;
      else if (ex_type == 2'd1) e_act = (ex_pc & 32'hF000_0000) | ({6'b0, ex_imm26} * 4);
      else                      e_act = ex_a;
      e_pred = ex_pred_taken ? ex_pred_tgt : ex_pc + 8;
      e_miss = ex_valid && (e_act != e_pred);
      e_npc  = e_miss ? e_act : (m_pend ? m_ptgt : pc_f + 4);
      check("npc_f", npc_f, e_npc);
      check("pred_taken_f", {31'b0, pred_taken_f}, {31'b0, e_pt});
      check("pred_tgt_f", pred_tgt_f, e_ptgt);
      check("flush_f", {31'b0, flush_f}, {31'b0, e_miss});
      check("perf_br", perf_br, m_br[31:0]);
      check("perf_miss", perf_miss, m_miss[31:0]);
      @(posedge clk);
      if (reset) begin
        if (ex_valid) begin
          if (m_br < 64'hFFFF_FFFF) m_br++;
          if (e_miss && m_miss < 64'hFFFF_FFFF) m_miss++;
          sx = slot(ex_pc);
          e_hit = m_hit(ex_pc);
          if (ex_type == 2'd0) begin
            if (e_hit) begin
              if (e_tk) begin m_tgt[sx] = e_act; m_cnt[sx] = (m_cnt[sx] < 3) ? m_cnt[sx] + 1 : 3; end
              else m_cnt[sx] = (m_cnt[sx] > 0) ? m_cnt[sx] - 1 : 0;
            end else if (e_tk) begin
              m_vld[sx] = 1; m_owner[sx] = ex_pc; m_tgt[sx] = e_act; m_cnt[sx] = 2;
            end
          end else if (ex_type == 2'd1) begin
            m_vld[sx] = 1; m_owner[sx] = ex_pc; m_tgt[sx] = e_act; m_cnt[sx] = 3;
          end
        end
        if (e_miss) m_pend = 0;
        else if (fetch_en) begin
          if (m_pend) m_pend = 0;
          else if (e_pt) begin m_pend = 1; m_ptgt = e_ptgt; end
        end
      end
    end
  end

  task automatic ex_none();
    ex_valid = 0; ex_type = 0; ex_cmpop = 0; ex_pc = 0; ex_a = 0; ex_b = 0;
    ex_imm32 = 0; ex_imm26 = 0; ex_pred_taken = 0; ex_pred_tgt = 0;
  endtask

  task automatic ex_br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic ptk,
                       input logic [31:0] ptgt);
    ex_valid = 1; ex_type = 2'd0; ex_cmpop = op; ex_pc = pc; ex_a = a; ex_b = b;
    ex_imm32 = imm; ex_pred_taken = ptk; ex_pred_tgt = ptgt;
  endtask

  task automatic ex_jmp(input logic [31:0] pc, input logic [25:0] idx26);
    ex_valid = 1; ex_type = 2'd1; ex_pc = pc; ex_imm26 = idx26;
  endtask

  task automatic ex_jr(input logic [31:0] pc, input logic [31:0] a);
    ex_valid = 1; ex_type = 2'd2; ex_pc = pc; ex_a = a;
  endtask

  task automatic fetch(input logic fe, input logic [31:0] pc);
    fetch_en = fe; pc_f = pc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    ex_none();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        tk;
  } cmp_vec_t;

  cmp_vec_t cmp_vecs[16] = '{
    '{3'd0, 32'd5, 32'd5, 1'b1}, '{3'd0, 32'd5, 32'd6, 1'b0},
    '{3'd1, 32'd5, 32'd6, 1'b1}, '{3'd1, 32'd5, 32'd5, 1'b0},
    '{3'd2, 32'd0, 32'd9, 1'b1}, '{3'd2, 32'd1, 32'd0, 1'b0},
    '{3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1}, '{3'd3, 32'd0, 32'd0, 1'b0},
    '{3'd3, 32'd1, 32'd0, 1'b1}, '{3'd3, 32'h8000_0000, 32'd0, 1'b0},
    '{3'd4, 32'hFFFF_FFFF, 32'd0, 1'b1}, '{3'd4, 32'd0, 32'd0, 1'b0},
    '{3'd5, 32'd0, 32'd0, 1'b1}, '{3'd5, 32'hFFFF_FFFB, 32'd0, 1'b0},
    '{3'd6, 32'd5, 32'd5, 1'b0}, '{3'd7, 32'd5, 32'd6, 1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0;
    fetch(0, 32'h0);
    ex_none();
    tick();
    fetch(1, 32'h3000); #1;
    check("rst_npc", npc_f, 32'h3004);
    check("rst_pt", {31'b0, pred_taken_f}, 32'h0);
    check("rst_flush", {31'b0, flush_f}, 32'h0);

    // 1: straight-line fetch
    tick(); reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); fetch(1, 32'h3000 + 32'(4 * i));
    end
    #1;
    check("seq_npc", npc_f, 32'h3010);
    check("seq_perf", perf_br, 32'h0);

    // 2: beq cold miss, then predicted taken with delay slot
    tick(); fetch(1, 32'h3000);
    tick(); fetch(1, 32'h3004);
    tick(); fetch(1, 32'h3008); ex_br(3'd0, 32'h3000, 5, 5, 3, 0, 0); #1;
    check("beq_cold_flush", {31'b0, flush_f}, 32'h1);
    check("beq_cold_npc", npc_f, 32'h3010);
    tick(); fetch(1, 32'h3010);
    tick(); fetch(1, 32'h3000); #1;
    check("beq_pred_tk", {31'b0, pred_taken_f}, 32'h1);
    check("beq_pred_tgt", pred_tgt_f, 32'h3010);
    check("beq_pred_npc", npc_f, 32'h3004);
    tick(); fetch(1, 32'h3004); #1;
    check("dslot_npc", npc_f, 32'h3010);
    check("dslot_pt", {31'b0, pred_taken_f}, 32'h0);
    tick(); fetch(1, 32'h3010); ex_br(3'd0, 32'h3000, 7, 7, 3, 1, 32'h3010); #1;
    check("beq_hit_flush", {31'b0, flush_f}, 32'h0);
    check("beq_hit_npc", npc_f, 32'h3014);
    check("beq_perf_miss", perf_miss, 32'h1);

    // 3: bne trained to 3, then not taken
    tick(); fetch(1, 32'h3800); ex_br(3'd1, 32'h3120, 1, 2, 4, 0, 0);
    tick(); fetch(1, 32'h3804); ex_br(3'd1, 32'h3120, 1, 2, 4, 1, 32'h3134);
    tick(); fetch(1, 32'h3808); ex_br(3'd1, 32'h3120, 9, 9, 4, 1, 32'h3134); #1;
    check("bne_nt_flush", {31'b0, flush_f}, 32'h1);
    check("bne_nt_npc", npc_f, 32'h3128);
    tick(); fetch(0, 32'h3120); #1;
    check("bne_still_tk", {31'b0, pred_taken_f}, 32'h1);
    check("bne_tgt", pred_tgt_f, 32'h3134);

    // 4: jr never allocated; j allocated strongly taken
    tick(); fetch(1, 32'h380c); ex_jr(32'h3200, 32'h3400); #1;
    check("jr_flush", {31'b0, flush_f}, 32'h1);
    check("jr_npc", npc_f, 32'h3400);
    tick(); fetch(0, 32'h3200); ex_jr(32'h3200, 32'h3208); #1;
    check("jr_no_alloc", {31'b0, pred_taken_f}, 32'h0);
    check("jr_seq_ok", {31'b0, flush_f}, 32'h0);
    tick(); fetch(1, 32'h3840); ex_jmp(32'h3204, 26'h0D00); #1;
    check("j_npc", npc_f, 32'h3400);
    tick(); fetch(0, 32'h3204); #1;
    check("j_pred_tk", {31'b0, pred_taken_f}, 32'h1);
    check("j_pred_tgt", pred_tgt_f, 32'h3400);

    // 5: pending target held across stalls; redirect overrides pending
    tick(); fetch(1, 32'h3204);
    for (int i = 0; i < 3; i++) begin
      tick(); fetch(0, 32'h3208); #1;
      check("pend_hold", npc_f, 32'h3400);
    end
    tick(); fetch(1, 32'h3208);
    tick(); fetch(1, 32'h3400); #1;
    check("pend_clear", npc_f, 32'h3404);
    tick(); fetch(1, 32'h3204);
    tick(); fetch(1, 32'h3208); ex_jr(32'h3300, 32'h3500); #1;
    check("pend_redirect", npc_f, 32'h3500);
    tick(); fetch(1, 32'h3500); #1;
    check("pend_dropped", npc_f, 32'h3504);

    // comparator ops, including the unused encodings
    foreach (cmp_vecs[k]) begin
      tick(); fetch(1, 32'h3900);
      ex_br(cmp_vecs[k].op, 32'h3310, cmp_vecs[k].a, cmp_vecs[k].b, 2, 0, 0); #1;
      check($sformatf("cmp_op%0d_%0d", cmp_vecs[k].op, k), {31'b0, flush_f}, {31'b0, cmp_vecs[k].tk});
    end

    // 6: index aliasing and reset mid-run
    tick(); fetch(1, 32'h3900); ex_jmp(32'h3040, 26'h0D80); #1;
    check("alias_npc", npc_f, 32'h3600);
    tick(); fetch(0, 32'h3000); #1;
    check("alias_old_miss", {31'b0, pred_taken_f}, 32'h0);
    check("alias_old_tgt", pred_tgt_f, 32'h0);
    tick(); fetch(0, 32'h3040); #1;
    check("alias_new_tgt", pred_tgt_f, 32'h3600);
    tick(); fetch(1, 32'h3040);
    tick(); fetch(1, 32'h3044); #2;
    reset = 0; #1;
    check("rst_pend_drop", npc_f, 32'h3048);
    check("rst_perf_br", perf_br, 32'h0);
    check("rst_perf_miss", perf_miss, 32'h0);
    tick();
    tick(); reset = 1;
    fetch(0, 32'h3040); #1;
    check("rst_btb_clear", {31'b0, pred_taken_f}, 32'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
